// File: rtl/dreg_pipe.sv
// Multi-lane elastic register pipeline: DEPTH valid/ready stages carrying M lanes
// of N-bit data, with bubble collapsing, per-lane enable, flush and occupancy count.
module dreg_pipe #(
  parameter int             N         = 2,
  parameter int             M         = 2,
  parameter int             DEPTH     = 3,
  parameter logic [N-1:0]   RESET_VAL = '0,
  localparam int            OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [M-1:0]     in_lane_en,
  input  logic [N-1:0]     d [M],
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     q [M],
  output logic [OCC_W-1:0] occupancy
);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] vld_next;
  logic [DEPTH-1:0] adv;
  logic [N-1:0]     data [DEPTH][M];
  logic [OCC_W-1:0] occ_next;
  logic             push;

  // A stage advances unless it and every stage after it are valid while the
  // output is stalled; this is the unrolled form of adv[k] = !vld[k] || adv[k+1].
  always_comb begin : advance
    logic all_full;
    all_full = 1'b1;
    adv      = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      all_full = all_full & vld[k];
      adv[k]   = ~all_full | out_ready;
    end
  end

  assign in_ready = adv[0] & ~flush;
  assign push     = in_valid & in_ready;

  always_comb begin
    vld_next = vld;
    if (flush) begin
      vld_next = '0;
    end else begin
      if (push)        vld_next[0] = 1'b1;
      else if (adv[0]) vld_next[0] = 1'b0;
      for (int k = 1; k < DEPTH; k++) begin
        if (adv[k]) vld_next[k] = vld[k-1];
      end
    end
    occ_next = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_next = occ_next + OCC_W'(vld_next[k]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // its neighbour's pre-edge value regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld       <= '0;
      occupancy <= '0;
    end else begin
      vld       <= vld_next;
      occupancy <= occ_next;
    end
  end

  // NOTE: the data array is reset on purpose, because q must show RESET_VAL
  // straight out of reset; loads are gated by source validity so bubbles and
  // flushes leave the registers untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        for (int j = 0; j < M; j++) data[k][j] <= RESET_VAL;
      end
    end else begin
      if (push) begin
        for (int j = 0; j < M; j++) data[0][j] <= in_lane_en[j] ? d[j] : RESET_VAL;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (!flush && adv[k] && vld[k-1]) begin
          for (int j = 0; j < M; j++) data[k][j] <= data[k-1][j];
        end
      end
    end
  end

  assign out_valid = vld[DEPTH-1];

  always_comb begin
    for (int j = 0; j < M; j++) q[j] = data[DEPTH-1][j];
  end

endmodule

// File: tb/tb_dreg_pipe.sv
// Self-checking bench for dreg_pipe: directed vector table, hand-written corner
// sequences and randomized traffic checked against a queue-based reference model.
module tb_dreg_pipe;

  localparam int           N     = 8;
  localparam int           M     = 4;
  localparam int           DEPTH = 3;
  localparam logic [N-1:0] RV    = 8'h00;
  localparam int           OW    = $clog2(DEPTH + 1);
  localparam int           WW    = N * M;

  logic          clock = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [M-1:0]  in_lane_en;
  logic [N-1:0]  d [M];
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  q [M];
  logic [OW-1:0] occupancy;

  int total = 0;
  int bad   = 0;
  bit model_on = 1'b0;

  always #5 clock = ~clock;

  dreg_pipe #(.N(N), .M(M), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_lane_en (in_lane_en),
    .d          (d),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .q          (q),
    .occupancy  (occupancy)
  );

  // Reference model: words in flight, oldest first, each with its stage position.
  typedef struct {
    logic [WW-1:0] w;
    int            pos;
  } ent_t;

  ent_t          mq[$];
  logic [WW-1:0] last_q;

  typedef struct {
    bit          iv;
    logic [3:0]  en;
    logic [31:0] dw;
    bit          orr;
    bit          fl;
    bit          e_ir;
    bit          e_ov;
    int          e_occ;
    logic [31:0] e_q;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] q_packed();
    logic [WW-1:0] r;
    for (int j = 0; j < M; j++) r[j*N +: N] = q[j];
    return r;
  endfunction

  function automatic logic [WW-1:0] masked(input logic [M-1:0] en, input logic [WW-1:0] dw);
    logic [WW-1:0] r;
    for (int j = 0; j < M; j++) r[j*N +: N] = en[j] ? dw[j*N +: N] : RV;
    return r;
  endfunction

  function automatic void model_reset();
    mq.delete();
    last_q = {M{RV}};
  endfunction

  function automatic logic [WW-1:0] d_packed();
    logic [WW-1:0] r;
    for (int j = 0; j < M; j++) r[j*N +: N] = d[j];
    return r;
  endfunction

  // One clock edge of the abstract pipe: pop the head if it is taken, slide every
  // word forward as far as the word ahead allows, then append the accepted input.
  function automatic void model_step();
    bit acc;
    int limit;
    int np;
    acc = in_valid && !flush && (mq.size() < DEPTH || out_ready);
    if (mq.size() > 0 && mq[0].pos == DEPTH - 1 && out_ready) void'(mq.pop_front());
    if (flush) begin
      mq.delete();
    end else begin
      limit = DEPTH;
      for (int i = 0; i < mq.size(); i++) begin
        np = (mq[i].pos + 1 < limit - 1) ? mq[i].pos + 1 : limit - 1;
        if (np == DEPTH - 1 && mq[i].pos != DEPTH - 1) last_q = mq[i].w;
        mq[i].pos = np;
        limit = np;
      end
      if (acc) mq.push_back('{w: masked(in_lane_en, d_packed()), pos: 0});
    end
  endfunction

  task automatic drive(input bit iv, input logic [M-1:0] en, input logic [WW-1:0] dw,
                       input bit orr, input bit fl);
    in_valid   = iv;
    in_lane_en = en;
    for (int j = 0; j < M; j++) d[j] = dw[j*N +: N];
    out_ready  = orr;
    flush      = fl;
  endtask

  task automatic model_check();
    check("in_ready",  in_ready,   !flush && (mq.size() < DEPTH || out_ready));
    check("out_valid", out_valid,  mq.size() > 0 && mq[0].pos == DEPTH - 1);
    check("occupancy", occupancy,  mq.size());
    check("q",         q_packed(), last_q);
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic cycle(input bit iv, input logic [M-1:0] en, input logic [WW-1:0] dw,
                       input bit orr, input bit fl);
    drive(iv, en, dw, orr, fl);
    #1;
    if (model_on) model_check();
    tick();
  endtask

  task automatic do_reset();
    drive(1'b0, '1, '0, 1'b1, 1'b0);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    // Directed vectors, sampled before each edge:
    //   iv   en     d            orr fl  in_ready out_valid occ  q
    tbl[0]  = '{1, 4'hf, 32'h04030201, 1, 0, 1, 0, 0, 32'h00000000};
    tbl[1]  = '{1, 4'hf, 32'h08070605, 1, 0, 1, 0, 1, 32'h00000000};
    tbl[2]  = '{1, 4'hf, 32'h0c0b0a09, 1, 0, 1, 0, 2, 32'h00000000};
    tbl[3]  = '{0, 4'hf, 32'h00000000, 0, 0, 0, 1, 3, 32'h04030201};
    tbl[4]  = '{1, 4'hf, 32'h100f0e0d, 0, 0, 0, 1, 3, 32'h04030201};
    tbl[5]  = '{1, 4'hf, 32'h100f0e0d, 1, 0, 1, 1, 3, 32'h04030201};
    tbl[6]  = '{0, 4'hf, 32'h00000000, 1, 0, 1, 1, 3, 32'h08070605};
    tbl[7]  = '{1, 4'h5, 32'hddccbbaa, 0, 0, 1, 1, 2, 32'h0c0b0a09};
    tbl[8]  = '{1, 4'hf, 32'h55555555, 0, 1, 0, 1, 3, 32'h0c0b0a09};
    tbl[9]  = '{1, 4'h5, 32'hddccbbaa, 1, 0, 1, 0, 0, 32'h0c0b0a09};
    tbl[10] = '{0, 4'hf, 32'h00000000, 1, 0, 1, 0, 1, 32'h0c0b0a09};
    tbl[11] = '{0, 4'hf, 32'h00000000, 1, 0, 1, 0, 1, 32'h0c0b0a09};
    tbl[12] = '{0, 4'hf, 32'h00000000, 1, 0, 1, 1, 1, 32'h00cc00aa};
    tbl[13] = '{0, 4'hf, 32'h00000000, 1, 0, 1, 0, 0, 32'h00cc00aa};

    drive(1'b0, '1, '0, 1'b1, 1'b0);
    reset = 1'b1;
    model_reset();
    #3;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_occupancy", occupancy, 0);
    check("reset_q", q_packed(), {M{RV}});
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("reset_in_ready", in_ready, 1'b1);
    @(negedge clock);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].iv, tbl[i].en, tbl[i].dw, tbl[i].orr, tbl[i].fl);
      #1;
      check($sformatf("vec%0d_in_ready", i),  in_ready,   tbl[i].e_ir);
      check($sformatf("vec%0d_out_valid", i), out_valid,  tbl[i].e_ov);
      check($sformatf("vec%0d_occupancy", i), occupancy,  tbl[i].e_occ);
      check($sformatf("vec%0d_q", i),         q_packed(), tbl[i].e_q);
      tick();
    end

    // Bubble collapse: isolated words under a stalled output pack into the pipe.
    do_reset();
    @(negedge clock);
    model_on = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 1) begin
        #1;
        check("bubble_occupancy", occupancy, (i + 1) / 2);
      end
      cycle(i % 2 == 0, '1, {$urandom}, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, '1, {$urandom}, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, '1, '0, 1'b1, 1'b0);

    // Asynchronous reset between edges while words are in flight.
    cycle(1'b1, '1, 32'h11223344, 1'b0, 1'b0);
    cycle(1'b1, '1, 32'h55667788, 1'b0, 1'b0);
    cycle(1'b1, '1, 32'h99aabbcc, 1'b0, 1'b0);
    drive(1'b0, '1, '0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_out_valid", out_valid, 1'b0);
    check("async_occupancy", occupancy, 0);
    check("async_q", q_packed(), {M{RV}});
    @(negedge clock);
    reset = 1'b0;
    cycle(1'b1, 4'hf, 32'hcafef00d, 1'b1, 1'b0);
    cycle(1'b0, 4'hf, '0, 1'b1, 1'b0);
    cycle(1'b0, 4'hf, '0, 1'b1, 1'b0);
    #1;
    check("post_reset_out_valid", out_valid, 1'b1);
    check("post_reset_q", q_packed(), 32'hcafef00d);
    cycle(1'b0, 4'hf, '0, 1'b1, 1'b0);

    // Randomized traffic with stalls, lane masks and occasional flushes.
    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 3) != 0, 4'($urandom), {$urandom},
            $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, '1, '0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
